seq_detect_n: RTL and testbench

Parametrised symbol-sequence detector: watches a stream of SYM_W-bit symbols and flags when the last LEN valid symbols equal a run-time programmable pattern. Symbol 0 is a reserved clear symbol. Output is either sticky (latched until cleared) or a per-window level. A saturating hit counter sits alongside. The block is the general-width, general-length replacement for the fixed 2-bit, 3-symbol lock detector and drops into the same stream-monitoring position.

---
 rtl/seq_detect_pkg.sv | 21 ++
 rtl/seq_window.sv | 55 +++++
 rtl/seq_detect_n.sv | 110 +++++++++++
 tb/tb_seq_detect_n.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants and encodings for the seq_detect_n symbol-sequence detector.
package seq_detect_pkg;

  localparam int DEF_SYM_W = 2;
  localparam int DEF_LEN   = 3;
  localparam int DEF_CNT_W = 8;

  // Symbol value that wipes the history instead of being recorded.
  localparam int CLEAR_SYM = 0;

  typedef enum logic {
    MODE_LEVEL  = 1'b0,
    MODE_STICKY = 1'b1
  } mode_e;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } lock_e;

endpackage

// File: rtl/seq_window.sv
// LEN-deep symbol history with saturating fill count; win_nxt/full_nxt show the
// window as it would look after shifting sym_in, so the caller can compare ahead.
module seq_window #(
  parameter int SYM_W = 2,
  parameter int LEN   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift,
  input  logic                 clr,
  input  logic [SYM_W-1:0]     sym_in,
  output logic [SYM_W*LEN-1:0] win_nxt,
  output logic                 full_nxt
);

  localparam int FW = $clog2(LEN + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(LEN);

  logic [SYM_W*LEN-1:0] win_q, win_d;
  logic [FW-1:0]        fill_q, fill_d;

  // Newest symbol enters at the top slot; slot 0 holds the oldest.
  generate
    if (LEN == 1) begin : g_one
      assign win_nxt = sym_in;
    end else begin : g_many
      assign win_nxt = {sym_in, win_q[SYM_W*LEN-1:SYM_W]};
    end
  endgenerate

  assign full_nxt = (fill_q >= (FILL_MAX - FW'(1)));

  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    if (clr) begin
      win_d  = '0;
      fill_d = '0;
    end else if (shift) begin
      win_d = win_nxt;
      if (fill_q != FILL_MAX) fill_d = fill_q + FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_n.sv
// Programmable LEN-symbol sequence detector, sticky or level output, 1-edge latency.
// Define SEQ_DETECT_CNT_EN to build the saturating hit counter; otherwise hit_cnt is 0.
module seq_detect_n
  import seq_detect_pkg::*;
#(
  parameter int                   SYM_W       = DEF_SYM_W,
  parameter int                   LEN         = DEF_LEN,
  parameter int                   CNT_W       = DEF_CNT_W,
  parameter logic [SYM_W*LEN-1:0] DEF_PATTERN = 'h39,
  parameter bit                   DEF_STICKY  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [SYM_W*LEN-1:0] cfg_pattern,
  input  logic                 cfg_sticky,
  input  logic                 in_valid,
  input  logic [SYM_W-1:0]     num,
  output logic                 ans,
  output logic                 hit,
  output logic [CNT_W-1:0]     hit_cnt
);

  logic [SYM_W*LEN-1:0] pattern_q, pattern_d;
  mode_e                mode_q, mode_d;
  lock_e                lock_q, lock_d;
  logic                 ans_q, ans_d;
  logic                 hit_q, hit_d;
  logic                 win_shift, win_clr, full_nxt, match;
  logic [SYM_W*LEN-1:0] win_nxt;

  seq_window #(.SYM_W(SYM_W), .LEN(LEN)) u_window (
    .clk      (clk),
    .reset    (reset),
    .shift    (win_shift),
    .clr      (win_clr),
    .sym_in   (num),
    .win_nxt  (win_nxt),
    .full_nxt (full_nxt)
  );

  // A pattern holding the clear symbol can never equal a window, which never stores one.
  assign match = full_nxt && (win_nxt == pattern_q);

  always_comb begin
    pattern_d = pattern_q;
    mode_d    = mode_q;
    lock_d    = lock_q;
    ans_d     = ans_q;
    hit_d     = 1'b0;
    win_shift = 1'b0;
    win_clr   = 1'b0;
    if (cfg_we) begin
      pattern_d = cfg_pattern;
      mode_d    = mode_e'(cfg_sticky);
      win_clr   = 1'b1;
      lock_d    = ST_HUNT;
      ans_d     = 1'b0;
    end else if (in_valid) begin
      if (num == SYM_W'(CLEAR_SYM)) begin
        win_clr = 1'b1;
        lock_d  = ST_HUNT;
        ans_d   = 1'b0;
      end else if (lock_q == ST_HUNT) begin
        win_shift = 1'b1;
        ans_d     = match;
        hit_d     = match;
        if (match && mode_q == MODE_STICKY) lock_d = ST_LOCK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q <= DEF_PATTERN;
      mode_q    <= mode_e'(DEF_STICKY);
      lock_q    <= ST_HUNT;
      ans_q     <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      mode_q    <= mode_d;
      lock_q    <= lock_d;
      ans_q     <= ans_d;
      hit_q     <= hit_d;
    end
  end

  assign ans = ans_q;
  assign hit = hit_q;

`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (hit_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign hit_cnt = cnt_q;
`else
  assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_n.sv
// Directed table-driven bench for seq_detect_n at default parameters.
module tb_seq_detect_n;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_we = 1'b0;
  logic [5:0] cfg_pattern = '0;
  logic       cfg_sticky = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] num = '0;
  logic       ans, hit;
  logic [7:0] hit_cnt;

`ifdef SEQ_DETECT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  seq_detect_n dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_sticky  (cfg_sticky),
    .in_valid    (in_valid),
    .num         (num),
    .ans         (ans),
    .hit         (hit),
    .hit_cnt     (hit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       we;
    logic [5:0] pat;
    logic       stk;
    logic       vld;
    logic [1:0] sym;
    logic       e_ans;
    logic       e_hit;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic rst, logic we, logic [5:0] pat, logic stk,
                              logic vld, logic [1:0] sym,
                              logic e_ans, logic e_hit, logic [7:0] e_cnt);
    vec_t v;
    v.rst = rst; v.we = we; v.pat = pat; v.stk = stk;
    v.vld = vld; v.sym = sym;
    v.e_ans = e_ans; v.e_hit = e_hit; v.e_cnt = CNT_EN ? e_cnt : 8'd0;
    return v;
  endfunction

  function automatic vec_t sy(logic [1:0] s, logic a, logic h, logic [7:0] c);
    return mk(1'b0, 1'b0, 6'h0, 1'b0, 1'b1, s, a, h, c);
  endfunction

  function automatic vec_t idl(logic a, logic [7:0] c);
    return mk(1'b0, 1'b0, 6'h0, 1'b0, 1'b0, 2'd0, a, 1'b0, c);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    @(negedge clk);
    reset = v.rst; cfg_we = v.we; cfg_pattern = v.pat; cfg_sticky = v.stk;
    in_valid = v.vld; num = v.sym;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Default pattern 1,2,3, sticky.
    vecs.push_back(mk(1'b1, 1'b0, 6'h0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 8'd0));
    vecs.push_back(sy(2'd1, 0, 0, 0));
    vecs.push_back(sy(2'd2, 0, 0, 0));
    vecs.push_back(sy(2'd3, 1, 1, 1));
    vecs.push_back(sy(2'd2, 1, 0, 1));
    vecs.push_back(sy(2'd1, 1, 0, 1));
    vecs.push_back(sy(2'd3, 1, 0, 1));
    vecs.push_back(sy(2'd0, 0, 0, 1));
    // Retry of first symbol: 1,1,2,3 matches on the 3.
    vecs.push_back(sy(2'd1, 0, 0, 1));
    vecs.push_back(sy(2'd1, 0, 0, 1));
    vecs.push_back(sy(2'd2, 0, 0, 1));
    vecs.push_back(sy(2'd3, 1, 1, 2));
    vecs.push_back(sy(2'd0, 0, 0, 2));
    // Clear symbol inside the sequence breaks it.
    vecs.push_back(sy(2'd1, 0, 0, 2));
    vecs.push_back(sy(2'd2, 0, 0, 2));
    vecs.push_back(sy(2'd0, 0, 0, 2));
    vecs.push_back(sy(2'd3, 0, 0, 2));
    vecs.push_back(sy(2'd0, 0, 0, 2));
    // Gaps between valid symbols.
    vecs.push_back(sy(2'd1, 0, 0, 2));
    vecs.push_back(idl(0, 2));
    vecs.push_back(sy(2'd2, 0, 0, 2));
    vecs.push_back(idl(0, 2));
    vecs.push_back(idl(0, 2));
    vecs.push_back(sy(2'd3, 1, 1, 3));
    vecs.push_back(idl(1, 3));
    vecs.push_back(idl(1, 3));
    vecs.push_back(sy(2'd0, 0, 0, 3));
    // Reset after 1,2 discards the partial window.
    vecs.push_back(sy(2'd1, 0, 0, 3));
    vecs.push_back(sy(2'd2, 0, 0, 3));
    vecs.push_back(mk(1'b1, 1'b0, 6'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0));
    vecs.push_back(sy(2'd3, 0, 0, 0));
    vecs.push_back(sy(2'd0, 0, 0, 0));
    // Config together with a symbol: symbol dropped, window cleared.
    vecs.push_back(sy(2'd1, 0, 0, 0));
    vecs.push_back(sy(2'd2, 0, 0, 0));
    vecs.push_back(mk(1'b0, 1'b1, 6'h39, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 8'd0));
    vecs.push_back(sy(2'd3, 0, 0, 0));
    vecs.push_back(sy(2'd1, 0, 0, 0));
    vecs.push_back(sy(2'd2, 0, 0, 0));
    vecs.push_back(sy(2'd3, 1, 1, 1));
    // Level mode pattern 1,1,1: overlapping hits, cfg keeps the count.
    vecs.push_back(mk(1'b0, 1'b1, 6'h15, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd1));
    vecs.push_back(sy(2'd1, 0, 0, 1));
    vecs.push_back(sy(2'd1, 0, 0, 1));
    vecs.push_back(sy(2'd1, 1, 1, 2));
    vecs.push_back(sy(2'd1, 1, 1, 3));
    vecs.push_back(sy(2'd2, 0, 0, 3));
    vecs.push_back(sy(2'd1, 0, 0, 3));
    // Pattern 1,0,1 holds a clear symbol and never matches.
    vecs.push_back(mk(1'b0, 1'b1, 6'h11, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd3));
    vecs.push_back(sy(2'd1, 0, 0, 3));
    vecs.push_back(sy(2'd1, 0, 0, 3));
    vecs.push_back(sy(2'd1, 0, 0, 3));
    vecs.push_back(sy(2'd1, 0, 0, 3));
    // Level mode 1,2,3: ans drops on the next non-matching window, holds on idle.
    vecs.push_back(mk(1'b0, 1'b1, 6'h39, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd3));
    vecs.push_back(sy(2'd1, 0, 0, 3));
    vecs.push_back(sy(2'd2, 0, 0, 3));
    vecs.push_back(sy(2'd3, 1, 1, 4));
    vecs.push_back(sy(2'd1, 0, 0, 4));
    vecs.push_back(sy(2'd2, 0, 0, 4));
    vecs.push_back(sy(2'd3, 1, 1, 5));
    vecs.push_back(idl(1, 5));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      check($sformatf("v%0d_ans", i), 32'(ans), 32'(vecs[i].e_ans));
      check($sformatf("v%0d_hit", i), 32'(hit), 32'(vecs[i].e_hit));
      check($sformatf("v%0d_cnt", i), 32'(hit_cnt), 32'(vecs[i].e_cnt));
    end

    // Counter saturation: level pattern 1,1,1 fed 300 ones gives 298 hits.
    begin
      logic [7:0] model_cnt;
      logic [7:0] exp_cnt;
      model_cnt = 8'd5;
      apply(mk(1'b0, 1'b1, 6'h15, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0));
      for (int k = 0; k < 300; k++) begin
        apply(sy(2'd1, 0, 0, 0));
        if (k >= 2 && model_cnt != 8'hff) model_cnt = model_cnt + 8'd1;
        if (k == 2 || k == 251 || k == 299) begin
          exp_cnt = CNT_EN ? model_cnt : 8'd0;
          check($sformatf("sat%0d_cnt", k), 32'(hit_cnt), 32'(exp_cnt));
          check($sformatf("sat%0d_hit", k), 32'(hit), 32'd1);
          check($sformatf("sat%0d_ans", k), 32'(ans), 32'd1);
        end
      end
      apply(sy(2'd0, 0, 0, 0));
      exp_cnt = CNT_EN ? 8'hff : 8'd0;
      check("sat_clear_cnt", 32'(hit_cnt), 32'(exp_cnt));
      check("sat_clear_ans", 32'(ans), 32'd0);
      apply(mk(1'b1, 1'b0, 6'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0));
      check("final_rst_cnt", 32'(hit_cnt), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
